// File: rtl/axis_acq_sequencer.sv
// Acquisition sequencer for the circular-buffer capture chain: arm, pre-trigger fill, trigger, capture, done.
// Optional ACQ_TIMEOUT_EN adds cfg_timeout, which forces a trigger after a number of ARMED cycles.
module axis_acq_sequencer #(
    parameter int CNTR_WIDTH    = 32,
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNTR_WIDTH-1:0] cfg_pre,
    input  logic [CNTR_WIDTH-1:0] cfg_post,
`ifdef ACQ_TIMEOUT_EN
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
`endif
    input  logic                  ctl_arm,
    input  logic                  ctl_abort,
    input  logic                  trig_in,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic                  mon_tlast,
    input  logic [CNTR_WIDTH-1:0] pkt_trigger_pos,
    output logic                  pkt_aresetn,
    output logic                  pkt_trigger,
    output logic [CNTR_WIDTH-1:0] pkt_cfg_data,
    output logic [2:0]            sts_state,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_forced,
    output logic [CNTR_WIDTH-1:0] sts_start_pos
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_PRETRIG = 3'd2,
        S_ARMED   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_trig_d;
    logic                  r_rst_cnt;
    logic [CNTR_WIDTH-1:0] r_beat_cnt;
    logic [CNTR_WIDTH-1:0] r_pre;
    logic [CNTR_WIDTH-1:0] r_cfg_data;
    logic [CNTR_WIDTH-1:0] r_start_pos;
    logic                  r_pkt_aresetn;
    logic                  r_pkt_trigger;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_beat;
    logic                  w_edge;
    logic                  w_arm_go;
    logic                  w_tmo_hit;
    logic [CNTR_WIDTH-1:0] w_beat_inc;

    assign w_beat     = mon_tvalid & mon_tready;
    assign w_edge     = trig_in & ~r_trig_d;
    assign w_beat_inc = r_beat_cnt + 1'b1;
    assign w_arm_go   = (w_next == S_RESET) && (r_state != S_RESET);

`ifdef ACQ_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] r_tmo_cfg;
    logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;
    logic [TIMEOUT_WIDTH-1:0] w_tmo_inc;
    logic                     r_forced;

    assign w_tmo_inc = r_tmo_cnt + 1'b1;
    // A zero timeout disables forcing; the count tracks completed ARMED cycles.
    assign w_tmo_hit = (r_tmo_cfg != '0) && (w_tmo_inc == r_tmo_cfg);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tmo_cfg <= '0;
            r_tmo_cnt <= '0;
            r_forced  <= 1'b0;
        end else begin
            if (w_arm_go) begin
                r_tmo_cfg <= cfg_timeout;
                r_forced  <= 1'b0;
            end
            if ((w_next == S_ARMED) && (r_state != S_ARMED)) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_ARMED) begin
                r_tmo_cnt <= w_tmo_inc;
            end
            if ((r_state == S_ARMED) && (w_next == S_CAPTURE) && !w_edge) begin
                r_forced <= 1'b1;
            end
        end
    end

    assign sts_forced = r_forced;
`else
    assign w_tmo_hit  = 1'b0;
    assign sts_forced = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (ctl_arm) w_next = S_RESET;
            S_RESET:   if (r_rst_cnt) w_next = S_PRETRIG;
            S_PRETRIG: if ((r_pre == '0) || (w_beat && (w_beat_inc == r_pre))) w_next = S_ARMED;
            S_ARMED:   if (w_edge || w_tmo_hit) w_next = S_CAPTURE;
            S_CAPTURE: if (w_beat && mon_tlast) w_next = S_DONE;
            S_DONE:    if (ctl_arm) w_next = S_RESET;
            default:   w_next = S_IDLE;
        endcase
        // Abort beats arm, tlast and trigger in every state.
        if (ctl_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_trig_d      <= 1'b0;
            r_rst_cnt     <= 1'b0;
            r_beat_cnt    <= '0;
            r_pre         <= '0;
            r_cfg_data    <= '0;
            r_start_pos   <= '0;
            r_pkt_aresetn <= 1'b0;
            r_pkt_trigger <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_trig_d      <= trig_in;
            r_pkt_aresetn <= (w_next == S_PRETRIG) || (w_next == S_ARMED) ||
                             (w_next == S_CAPTURE) || (w_next == S_DONE);
            r_pkt_trigger <= (w_next == S_CAPTURE) || (w_next == S_DONE);
            r_busy        <= (w_next == S_RESET) || (w_next == S_PRETRIG) ||
                             (w_next == S_ARMED) || (w_next == S_CAPTURE);
            r_done        <= (w_next == S_DONE);

            if (w_arm_go) begin
                r_cfg_data <= cfg_post;
                r_pre      <= cfg_pre;
                r_rst_cnt  <= 1'b0;
                r_beat_cnt <= '0;
            end else if (r_state == S_RESET) begin
                r_rst_cnt  <= 1'b1;
                r_beat_cnt <= '0;
            end else if ((r_state == S_PRETRIG) && w_beat) begin
                r_beat_cnt <= w_beat_inc;
            end

            // First pre-trigger beat sits cfg_pre positions behind the trigger beat.
            if ((r_state == S_CAPTURE) && (w_next == S_DONE)) begin
                r_start_pos <= pkt_trigger_pos - r_pre;
            end
        end
    end

    assign sts_state     = r_state;
    assign pkt_aresetn   = r_pkt_aresetn;
    assign pkt_trigger   = r_pkt_trigger;
    assign pkt_cfg_data  = r_cfg_data;
    assign sts_busy      = r_busy;
    assign sts_done      = r_done;
    assign sts_start_pos = r_start_pos;

endmodule

// File: tb/tb_axis_acq_sequencer.sv
// Directed self-checking bench for axis_acq_sequencer; the timeout scenario is built only with ACQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_axis_acq_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_pre;
    logic [31:0] cfg_post;
`ifdef ACQ_TIMEOUT_EN
    logic [31:0] cfg_timeout;
`endif
    logic        ctl_arm;
    logic        ctl_abort;
    logic        trig_in;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic [31:0] pkt_trigger_pos;
    logic        pkt_aresetn;
    logic        pkt_trigger;
    logic [31:0] pkt_cfg_data;
    logic [2:0]  sts_state;
    logic        sts_busy;
    logic        sts_done;
    logic        sts_forced;
    logic [31:0] sts_start_pos;

    int nAssert = 0;
    int nFail   = 0;

    axis_acq_sequencer #(.CNTR_WIDTH(32), .TIMEOUT_WIDTH(32)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .cfg_pre         (cfg_pre),
        .cfg_post        (cfg_post),
`ifdef ACQ_TIMEOUT_EN
        .cfg_timeout     (cfg_timeout),
`endif
        .ctl_arm         (ctl_arm),
        .ctl_abort       (ctl_abort),
        .trig_in         (trig_in),
        .mon_tvalid      (mon_tvalid),
        .mon_tready      (mon_tready),
        .mon_tlast       (mon_tlast),
        .pkt_trigger_pos (pkt_trigger_pos),
        .pkt_aresetn     (pkt_aresetn),
        .pkt_trigger     (pkt_trigger),
        .pkt_cfg_data    (pkt_cfg_data),
        .sts_state       (sts_state),
        .sts_busy        (sts_busy),
        .sts_done        (sts_done),
        .sts_forced      (sts_forced),
        .sts_start_pos   (sts_start_pos)
    );

    always #5 aclk = ~aclk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Arm, then sit through the two RESET cycles; returns with the DUT in PRETRIG.
    task automatic armAndWaitPretrig(input logic [31:0] pre, input logic [31:0] post);
        cfg_pre  = pre;
        cfg_post = post;
        ctl_arm  = 1'b1;
        tick();
        ctl_arm  = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        nAssert++; if (sts_state !== 3'd0) begin nFail++; $display("[TB] FAIL reset_state: got %0d want 0", sts_state); end
        nAssert++; if (pkt_aresetn !== 1'b0) begin nFail++; $display("[TB] FAIL reset_aresetn: got %b want 0", pkt_aresetn); end
        nAssert++; if (pkt_trigger !== 1'b0) begin nFail++; $display("[TB] FAIL reset_trigger: got %b want 0", pkt_trigger); end
        nAssert++; if (pkt_cfg_data !== 32'd0) begin nFail++; $display("[TB] FAIL reset_cfg: got %0d want 0", pkt_cfg_data); end
        nAssert++; if ({sts_busy, sts_done, sts_forced} !== 3'b000) begin nFail++; $display("[TB] FAIL reset_flags: got %b want 000", {sts_busy, sts_done, sts_forced}); end
        nAssert++; if (sts_start_pos !== 32'd0) begin nFail++; $display("[TB] FAIL reset_startpos: got %0d want 0", sts_start_pos); end
    endtask

    task automatic test_basic();
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; trig_in = 1'b0;
        pkt_trigger_pos = 32'd100;
        cfg_pre = 32'd8; cfg_post = 32'd16; ctl_arm = 1'b1;
        tick();
        ctl_arm = 1'b0;
        nAssert++; if (sts_state !== 3'd1) begin nFail++; $display("[TB] FAIL basic_reset1: got %0d want 1", sts_state); end
        nAssert++; if (pkt_cfg_data !== 32'd16) begin nFail++; $display("[TB] FAIL basic_cfg: got %0d want 16", pkt_cfg_data); end
        nAssert++; if ({sts_busy, pkt_aresetn} !== 2'b10) begin nFail++; $display("[TB] FAIL basic_busy_rstn: got %b want 10", {sts_busy, pkt_aresetn}); end
        tick();
        nAssert++; if ({sts_state, pkt_aresetn} !== {3'd1, 1'b0}) begin nFail++; $display("[TB] FAIL basic_reset2: got %0d/%b want 1/0", sts_state, pkt_aresetn); end
        tick();
        nAssert++; if ({sts_state, pkt_aresetn} !== {3'd2, 1'b1}) begin nFail++; $display("[TB] FAIL basic_pretrig: got %0d/%b want 2/1", sts_state, pkt_aresetn); end
        repeat (7) tick();
        nAssert++; if (sts_state !== 3'd2) begin nFail++; $display("[TB] FAIL basic_beat7: got %0d want 2", sts_state); end
        tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL basic_beat8: got %0d want 3", sts_state); end
        repeat (12) tick();
        nAssert++; if ({sts_state, pkt_trigger} !== {3'd3, 1'b0}) begin nFail++; $display("[TB] FAIL basic_waittrig: got %0d/%b want 3/0", sts_state, pkt_trigger); end
        trig_in = 1'b1;
        tick();
        nAssert++; if ({sts_state, pkt_trigger} !== {3'd4, 1'b1}) begin nFail++; $display("[TB] FAIL basic_capture: got %0d/%b want 4/1", sts_state, pkt_trigger); end
        repeat (3) tick();
        nAssert++; if (sts_done !== 1'b0) begin nFail++; $display("[TB] FAIL basic_notdone: got %b want 0", sts_done); end
        mon_tlast = 1'b1;
        tick();
        mon_tlast = 1'b0;
        nAssert++; if ({sts_state, sts_done, sts_busy} !== {3'd5, 1'b1, 1'b0}) begin nFail++; $display("[TB] FAIL basic_done: got %0d/%b/%b want 5/1/0", sts_state, sts_done, sts_busy); end
        nAssert++; if ({pkt_aresetn, pkt_trigger, sts_forced} !== 3'b110) begin nFail++; $display("[TB] FAIL basic_done_lines: got %b want 110", {pkt_aresetn, pkt_trigger, sts_forced}); end
        nAssert++; if (sts_start_pos !== 32'd92) begin nFail++; $display("[TB] FAIL basic_startpos: got %0d want 92", sts_start_pos); end
        trig_in = 1'b0;
    endtask

    task automatic test_early_trigger();
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; trig_in = 1'b0;
        pkt_trigger_pos = 32'd100;
        armAndWaitPretrig(32'd8, 32'd16);
        nAssert++; if (sts_state !== 3'd2) begin nFail++; $display("[TB] FAIL early_pretrig: got %0d want 2", sts_state); end
        repeat (3) tick();
        trig_in = 1'b1; ctl_arm = 1'b1; cfg_post = 32'd99;
        tick();
        trig_in = 1'b0; ctl_arm = 1'b0;
        nAssert++; if ({sts_state, pkt_trigger} !== {3'd2, 1'b0}) begin nFail++; $display("[TB] FAIL early_edge_ignored: got %0d/%b want 2/0", sts_state, pkt_trigger); end
        nAssert++; if (pkt_cfg_data !== 32'd16) begin nFail++; $display("[TB] FAIL early_arm_ignored: got %0d want 16", pkt_cfg_data); end
        repeat (3) tick();
        nAssert++; if (sts_state !== 3'd2) begin nFail++; $display("[TB] FAIL early_beat7: got %0d want 2", sts_state); end
        tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL early_armed: got %0d want 3", sts_state); end
        repeat (3) tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL early_no_queue: got %0d want 3", sts_state); end
        trig_in = 1'b1;
        tick();
        nAssert++; if ({sts_state, pkt_trigger} !== {3'd4, 1'b1}) begin nFail++; $display("[TB] FAIL early_capture: got %0d/%b want 4/1", sts_state, pkt_trigger); end
        mon_tlast = 1'b1;
        tick();
        mon_tlast = 1'b0; trig_in = 1'b0;
        nAssert++; if ({sts_state, sts_start_pos} !== {3'd5, 32'd92}) begin nFail++; $display("[TB] FAIL early_done: got %0d/%0d want 5/92", sts_state, sts_start_pos); end
    endtask

    task automatic test_zero_pre();
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0; trig_in = 1'b0;
        pkt_trigger_pos = 32'd50;
        armAndWaitPretrig(32'd0, 32'd4);
        nAssert++; if (sts_state !== 3'd2) begin nFail++; $display("[TB] FAIL zero_pretrig: got %0d want 2", sts_state); end
        trig_in = 1'b1;
        tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL zero_armed: got %0d want 3", sts_state); end
        tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL zero_high_not_edge: got %0d want 3", sts_state); end
        trig_in = 1'b0;
        tick();
        trig_in = 1'b1;
        tick();
        nAssert++; if (sts_state !== 3'd4) begin nFail++; $display("[TB] FAIL zero_capture: got %0d want 4", sts_state); end
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
        tick();
        mon_tlast = 1'b0; trig_in = 1'b0;
        nAssert++; if ({sts_state, sts_start_pos} !== {3'd5, 32'd50}) begin nFail++; $display("[TB] FAIL zero_done: got %0d/%0d want 5/50", sts_state, sts_start_pos); end
    endtask

    task automatic test_wrap();
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; trig_in = 1'b0;
        pkt_trigger_pos = 32'd2;
        armAndWaitPretrig(32'd4, 32'd8);
        repeat (4) tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL wrap_armed: got %0d want 3", sts_state); end
        trig_in = 1'b1;
        tick();
        mon_tlast = 1'b1;
        tick();
        mon_tlast = 1'b0; trig_in = 1'b0;
        nAssert++; if ({sts_state, sts_start_pos} !== {3'd5, 32'hFFFF_FFFE}) begin nFail++; $display("[TB] FAIL wrap_startpos: got %0d/%h want 5/fffffffe", sts_state, sts_start_pos); end
    endtask

    task automatic test_abort();
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; trig_in = 1'b0;
        pkt_trigger_pos = 32'd9;
        armAndWaitPretrig(32'd0, 32'd4);
        tick();
        trig_in = 1'b1;
        tick();
        nAssert++; if (sts_state !== 3'd4) begin nFail++; $display("[TB] FAIL abort_capture: got %0d want 4", sts_state); end
        ctl_abort = 1'b1; mon_tlast = 1'b1;
        tick();
        ctl_abort = 1'b0; mon_tlast = 1'b0; trig_in = 1'b0;
        nAssert++; if ({sts_state, pkt_aresetn, pkt_trigger, sts_done} !== {3'd0, 3'b000}) begin nFail++; $display("[TB] FAIL abort_idle: got %0d/%b%b%b want 0/000", sts_state, pkt_aresetn, pkt_trigger, sts_done); end
        nAssert++; if (sts_start_pos !== 32'hFFFF_FFFE) begin nFail++; $display("[TB] FAIL abort_retain: got %h want fffffffe", sts_start_pos); end
        armAndWaitPretrig(32'd0, 32'd4);
        tick();
        trig_in = 1'b1;
        tick();
        mon_tlast = 1'b1;
        tick();
        mon_tlast = 1'b0; trig_in = 1'b0;
        nAssert++; if ({sts_state, sts_start_pos} !== {3'd5, 32'd9}) begin nFail++; $display("[TB] FAIL abort_done: got %0d/%0d want 5/9", sts_state, sts_start_pos); end
        ctl_arm = 1'b1; ctl_abort = 1'b1;
        tick();
        ctl_arm = 1'b0; ctl_abort = 1'b0;
        nAssert++; if ({sts_state, pkt_aresetn, pkt_trigger} !== {3'd0, 2'b00}) begin nFail++; $display("[TB] FAIL abort_beats_arm: got %0d/%b%b want 0/00", sts_state, pkt_aresetn, pkt_trigger); end
        nAssert++; if (sts_start_pos !== 32'd9) begin nFail++; $display("[TB] FAIL abort_arm_retain: got %0d want 9", sts_start_pos); end
    endtask

    task automatic test_rearm_reset();
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; trig_in = 1'b0;
        pkt_trigger_pos = 32'd20;
        armAndWaitPretrig(32'd0, 32'd4);
        tick();
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0; mon_tlast = 1'b1;
        tick();
        mon_tlast = 1'b0;
        nAssert++; if (sts_state !== 3'd5) begin nFail++; $display("[TB] FAIL rearm_done: got %0d want 5", sts_state); end
        cfg_pre = 32'd2; cfg_post = 32'd32; ctl_arm = 1'b1;
        tick();
        ctl_arm = 1'b0;
        nAssert++; if ({sts_state, pkt_aresetn, pkt_trigger, sts_done} !== {3'd1, 3'b000}) begin nFail++; $display("[TB] FAIL rearm_reset1: got %0d/%b%b%b want 1/000", sts_state, pkt_aresetn, pkt_trigger, sts_done); end
        nAssert++; if (pkt_cfg_data !== 32'd32) begin nFail++; $display("[TB] FAIL rearm_cfg: got %0d want 32", pkt_cfg_data); end
        tick();
        nAssert++; if ({sts_state, pkt_aresetn} !== {3'd1, 1'b0}) begin nFail++; $display("[TB] FAIL rearm_reset2: got %0d/%b want 1/0", sts_state, pkt_aresetn); end
        tick();
        nAssert++; if ({sts_state, pkt_aresetn} !== {3'd2, 1'b1}) begin nFail++; $display("[TB] FAIL rearm_pretrig: got %0d/%b want 2/1", sts_state, pkt_aresetn); end
        areset = 1'b1; trig_in = 1'b1;
        tick();
        areset = 1'b0; trig_in = 1'b0;
        nAssert++; if ({sts_state, pkt_aresetn, pkt_trigger, sts_busy, sts_done, sts_forced} !== {3'd0, 5'b00000}) begin nFail++; $display("[TB] FAIL areset_flags: got %0d/%b want 0/00000", sts_state, {pkt_aresetn, pkt_trigger, sts_busy, sts_done, sts_forced}); end
        nAssert++; if ({pkt_cfg_data, sts_start_pos} !== 64'd0) begin nFail++; $display("[TB] FAIL areset_values: got %0d/%0d want 0/0", pkt_cfg_data, sts_start_pos); end
        tick();
        nAssert++; if (sts_state !== 3'd0) begin nFail++; $display("[TB] FAIL areset_stays_idle: got %0d want 0", sts_state); end
    endtask

`ifdef ACQ_TIMEOUT_EN
    task automatic test_timeout();
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0; trig_in = 1'b0;
        cfg_timeout = 32'd100;
        armAndWaitPretrig(32'd0, 32'd4);
        tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL tmo_armed: got %0d want 3", sts_state); end
        repeat (99) tick();
        nAssert++; if (sts_state !== 3'd3) begin nFail++; $display("[TB] FAIL tmo_cycle99: got %0d want 3", sts_state); end
        tick();
        nAssert++; if ({sts_state, sts_forced} !== {3'd4, 1'b1}) begin nFail++; $display("[TB] FAIL tmo_forced: got %0d/%b want 4/1", sts_state, sts_forced); end
        mon_tlast = 1'b1;
        tick();
        mon_tlast = 1'b0;
        armAndWaitPretrig(32'd0, 32'd4);
        nAssert++; if (sts_forced !== 1'b0) begin nFail++; $display("[TB] FAIL tmo_arm_clears: got %b want 0", sts_forced); end
        tick();
        repeat (99) tick();
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        nAssert++; if ({sts_state, sts_forced} !== {3'd4, 1'b0}) begin nFail++; $display("[TB] FAIL tmo_edge_wins: got %0d/%b want 4/0", sts_state, sts_forced); end
        ctl_abort = 1'b1;
        tick();
        ctl_abort = 1'b0;
        cfg_timeout = 32'd0;
    endtask
`endif

    initial begin
        areset = 1'b1; cfg_pre = '0; cfg_post = '0; ctl_arm = 1'b0; ctl_abort = 1'b0;
        trig_in = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        pkt_trigger_pos = '0;
`ifdef ACQ_TIMEOUT_EN
        cfg_timeout = '0;
`endif
        test_reset();
        test_basic();
        test_early_trigger();
        test_zero_pre();
        test_wrap();
        test_abort();
        test_rearm_reset();
`ifdef ACQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
